// File: rtl/phase_bus_card_responder_if.sv
// Phase-bus signals between the rack controller (master) and one lamp/ADC card (slave).
interface phase_bus_card_responder_if;
  logic [3:0] BOARD_X;
  logic [2:0] AddessPortPin;
  logic       RdP;
  logic       WrP;
  logic [7:0] bus_data_in;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;

  modport master (output BOARD_X, AddessPortPin, RdP, WrP, bus_data_in,
                  input  bus_data_out, bus_data_oe);
  modport slave  (input  BOARD_X, AddessPortPin, RdP, WrP, bus_data_in,
                  output bus_data_out, bus_data_oe);
endinterface

// File: rtl/phase_bus_card_responder.sv
// One lamp/ADC card on the phase bus: strobe decode, port latches, read-back mux
// and the mux-settle / convert sequencer. CARD_INDEX picks the BOARD_X bit.
module phase_bus_card_responder #(
  parameter int CARD_INDEX    = 0,
  parameter int SYNC_STAGES   = 2,
  parameter int CONV_CYCLES   = 40,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  phase_bus_card_responder_if.slave pb,
  input  logic        LampResetPin,
  input  logic [7:0]  card_inputs,
  input  logic [15:0] adc_sample,
  output logic [7:0]  lamp_out,
  output logic [7:0]  aux_out,
  output logic [7:0]  mux_channel,
  output logic        adc_busy,
  output logic        bus_error
);
  // sync word: {sel, addr[2:0], RdP, WrP, lamp_rst, data_in[7:0], card_inputs[7:0]}
  localparam int SW = 23;
  localparam logic [SW-1:0] SYNC_RST = {1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] CONV_LAST   = 8'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {B_IDLE, B_WRITE, B_READ} bstate_t;
  typedef enum logic [1:0] {A_IDLE, A_SETTLE, A_ARMED, A_CONVERT} astate_t;

  logic [SYNC_STAGES-1:0][SW-1:0] r_sync;
  logic [SW-1:0] w_raw, w_s;
  logic          w_sel, w_rd, w_wr, w_lrst;
  logic [2:0]    w_addr;
  logic [7:0]    w_din, w_cin;

  bstate_t    r_bst, w_bst_nx;
  astate_t    r_ast, w_ast_nx;
  logic [7:0] r_cnt;
  logic       w_cnt_clr;
  logic [7:0] r_wdata, r_lamp, r_aux, r_mux, r_scr4, r_scr7;
  logic [2:0] r_waddr;
  logic [15:0] r_res;
  logic       r_both_d, r_err;
  logic       w_commit, w_abort, w_both_new, w_oe, w_we, w_p3, w_p3_err, w_conv_done;
  logic [7:0] w_rdmux;

  assign w_raw = {pb.BOARD_X[CARD_INDEX], pb.AddessPortPin, pb.RdP, pb.WrP,
                  LampResetPin, pb.bus_data_in, card_inputs};

  // strobes reset to their inactive (high) level so release from reset is quiet
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_sync <= {SYNC_STAGES{SYNC_RST}};
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_sel  = w_s[22];
  assign w_addr = w_s[21:19];
  assign w_rd   = ~w_s[18];
  assign w_wr   = ~w_s[17];
  assign w_lrst = w_s[16];
  assign w_din  = w_s[15:8];
  assign w_cin  = w_s[7:0];

  // bus FSM
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)    r_bst <= B_IDLE;
    else if (w_lrst) r_bst <= B_IDLE;
    else             r_bst <= w_bst_nx;

  always_comb begin
    w_bst_nx = r_bst;
    case (r_bst)
      B_IDLE:  if (w_sel && w_wr && !w_rd)      w_bst_nx = B_WRITE;
               else if (w_sel && w_rd && !w_wr) w_bst_nx = B_READ;
      B_WRITE: if (w_rd || !w_sel || !w_wr)     w_bst_nx = B_IDLE;
      B_READ:  if (!w_rd || !w_sel)             w_bst_nx = B_IDLE;
      default:                                  w_bst_nx = B_IDLE;
    endcase
  end

  always_comb begin
    w_commit   = (r_bst == B_WRITE) && !w_wr && !w_rd && w_sel;
    w_abort    = (r_bst == B_WRITE) && (w_rd || !w_sel);
    w_both_new = (r_bst == B_IDLE) && w_sel && w_rd && w_wr && !r_both_d;
    w_oe       = (r_bst == B_READ);
  end

  assign w_we = w_commit && !w_lrst;
  assign w_p3 = w_we && (r_waddr == 3'd3);

  // last byte/address seen while WrP is low is what gets committed on release
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_wdata <= 8'h00;
      r_waddr <= 3'd0;
    end else if (w_wr) begin
      r_wdata <= w_din;
      r_waddr <= w_addr;
    end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n || w_lrst) begin
      r_lamp <= 8'h00; r_aux <= 8'h00; r_mux <= 8'h00; r_scr4 <= 8'h00; r_scr7 <= 8'h00;
    end else if (w_we) begin
      case (r_waddr)
        3'd1: r_lamp <= r_wdata;
        3'd2: r_aux  <= r_wdata;
        3'd3: if (r_ast == A_IDLE || r_ast == A_SETTLE) r_mux <= r_wdata;
        3'd4: r_scr4 <= r_wdata;
        3'd7: r_scr7 <= r_wdata;
        default: ;
      endcase
    end

  // ADC FSM
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_ast <= A_IDLE;
      r_cnt <= 8'h00;
    end else if (w_lrst) begin
      r_ast <= A_IDLE;
      r_cnt <= 8'h00;
    end else begin
      r_ast <= w_ast_nx;
      r_cnt <= w_cnt_clr ? 8'h00 : r_cnt + 8'h01;
    end

  always_comb begin
    w_ast_nx  = r_ast;
    w_cnt_clr = 1'b0;
    case (r_ast)
      A_IDLE:    if (w_p3) begin w_ast_nx = A_SETTLE; w_cnt_clr = 1'b1; end
      A_SETTLE:  if (w_p3) begin w_ast_nx = A_SETTLE; w_cnt_clr = 1'b1; end
                 else if (r_cnt == SETTLE_LAST) w_ast_nx = A_ARMED;
      A_ARMED:   if (w_p3) begin w_ast_nx = A_CONVERT; w_cnt_clr = 1'b1; end
      A_CONVERT: if (r_cnt == CONV_LAST) w_ast_nx = A_IDLE;
      default:   w_ast_nx = A_IDLE;
    endcase
  end

  always_comb begin
    adc_busy    = (r_ast == A_CONVERT);
    w_conv_done = (r_ast == A_CONVERT) && (r_cnt == CONV_LAST);
    w_p3_err    = w_p3 && (r_ast == A_CONVERT);
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n || w_lrst) r_res <= 16'h0000;
    else if (w_conv_done)   r_res <= adc_sample;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_both_d <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_both_d <= w_sel && w_rd && w_wr;
      r_err    <= !w_lrst && (w_both_new || w_abort || w_p3_err);
    end

  always_comb begin
    case (w_addr)
      3'd0:    w_rdmux = w_cin;
      3'd1:    w_rdmux = r_lamp;
      3'd2:    w_rdmux = r_aux;
      3'd3:    w_rdmux = r_mux;
      3'd4:    w_rdmux = r_scr4;
      3'd5:    w_rdmux = r_res[15:8];
      3'd6:    w_rdmux = r_res[7:0];
      default: w_rdmux = r_scr7;
    endcase
  end

  assign pb.bus_data_oe  = w_oe;
  assign pb.bus_data_out = w_oe ? w_rdmux : 8'h00;
  assign lamp_out        = r_lamp;
  assign aux_out         = r_aux;
  assign mux_channel     = r_mux;
  assign bus_error       = r_err;
endmodule

// File: tb/tb_phase_bus_card_responder.sv
// Four-card rack on one phase bus, checked against a transaction-level card model.
module tb_phase_bus_card_responder;
  localparam int SYNC = 2, CONV = 40, SETTLE = 4;

  logic clock = 1'b0, reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [3:0]  bx = 4'h0;
  logic [2:0]  addr = 3'd0;
  logic        rdp = 1'b1, wrp = 1'b1, lrst = 1'b0;
  logic [7:0]  din = 8'h00, cin = 8'h00;
  logic [15:0] adc = 16'h0000;

  logic       oe[4], busy[4], err[4];
  logic [7:0] dout[4], lamp[4], aux[4], mux[4];

  for (genvar g = 0; g < 4; g++) begin : card
    phase_bus_card_responder_if pb();
    assign pb.BOARD_X       = bx;
    assign pb.AddessPortPin = addr;
    assign pb.RdP           = rdp;
    assign pb.WrP           = wrp;
    assign pb.bus_data_in   = din;
    assign oe[g]            = pb.bus_data_oe;
    assign dout[g]          = pb.bus_data_out;
    phase_bus_card_responder #(.CARD_INDEX(g), .SYNC_STAGES(SYNC),
                               .CONV_CYCLES(CONV), .SETTLE_CYCLES(SETTLE)) dut (
      .clock(clock), .reset_n(reset_n), .pb(pb.slave), .LampResetPin(lrst),
      .card_inputs(cin), .adc_sample(adc), .lamp_out(lamp[g]), .aux_out(aux[g]),
      .mux_channel(mux[g]), .adc_busy(busy[g]), .bus_error(err[g]));
  end

  int total = 0, bad = 0;
  logic [7:0]  m_lamp[4], m_aux[4], m_mux[4], m_s4[4], m_s7[4];
  logic [15:0] m_res[4];
  int m_ph[4];   // 0 idle, 1 mux latched (armed by next write), 2 converting
  int m_err[4], e_cnt[4], run[4], last_run[4];
  bit stable = 0, rd_active = 0;
  logic [2:0] rd_port = 3'd0;
  logic [7:0] rd_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] exp_rd(input int i, input logic [2:0] p);
    case (p)
      3'd0: return cin;
      3'd1: return m_lamp[i];
      3'd2: return m_aux[i];
      3'd3: return m_mux[i];
      3'd4: return m_s4[i];
      3'd5: return m_res[i][15:8];
      3'd6: return m_res[i][7:0];
      default: return m_s7[i];
    endcase
  endfunction

  function automatic bit any_busy();
    return busy[0] | busy[1] | busy[2] | busy[3];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_lamp[i] = 0; m_aux[i] = 0; m_mux[i] = 0; m_s4[i] = 0; m_s7[i] = 0;
      m_res[i] = 0; m_ph[i] = 0;
    end
  endtask

  task automatic model_write(input logic [3:0] b, input logic [2:0] p, input logic [7:0] d);
    for (int i = 0; i < 4; i++) if (b[i]) begin
      case (p)
        3'd1: m_lamp[i] = d;
        3'd2: m_aux[i]  = d;
        3'd4: m_s4[i]   = d;
        3'd7: m_s7[i]   = d;
        3'd3: begin
          if (m_ph[i] == 0)      begin m_mux[i] = d; m_ph[i] = 1; end
          else if (m_ph[i] == 1) m_ph[i] = 2;
          else                   m_err[i]++;
        end
        default: ;
      endcase
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (err[i]) e_cnt[i]++;
      if (busy[i]) run[i]++;
      else if (run[i] != 0) begin last_run[i] = run[i]; run[i] = 0; end
      if (oe[i]) begin
        chk($sformatf("drive_slot%0d", i), {31'b0, rd_active & bx[i]}, 32'd1);
        if (rd_active) chk($sformatf("rd_data%0d", i), dout[i], exp_rd(i, rd_port));
      end
      if (stable) begin
        chk($sformatf("lamp%0d", i), lamp[i], m_lamp[i]);
        chk($sformatf("aux%0d", i),  aux[i],  m_aux[i]);
        chk($sformatf("mux%0d", i),  mux[i],  m_mux[i]);
      end
    end
  end

  task automatic wr(input logic [3:0] b, input logic [2:0] p, input logic [7:0] d);
    stable = 0; bx = b; addr = p; din = d;
    tick(1); wrp = 0;
    tick(4); wrp = 1;
    tick(SYNC + 3); bx = 0;
    model_write(b, p, d);
    tick(SYNC + 2); stable = 1;
  endtask

  task automatic rd(input logic [3:0] b, input logic [2:0] p, input logic [7:0] c);
    bit got = 0;
    bx = b; addr = p; cin = c; rd_port = p;
    tick(SYNC + 1);
    rd_active = 1; rdp = 0;
    for (int k = 1; k <= 21; k++) begin
      tick(1);
      if (k == SYNC + 1)
        for (int i = 0; i < 4; i++) if (b[i]) begin
          chk("rd_oe_latency", oe[i], 1);
          if (!got) begin rd_seen = dout[i]; got = 1; end
        end
    end
    rdp = 1;
    tick(SYNC);
    for (int i = 0; i < 4; i++) chk("rd_oe_hold", oe[i], b[i]);
    tick(1);
    for (int i = 0; i < 4; i++) chk("rd_oe_release", oe[i], 0);
    rd_active = 0; bx = 0;
    tick(2);
  endtask

  task automatic wait_conv();
    int n = 0;
    while (any_busy() && n < 400) begin tick(1); n++; end
    chk("conv_timeout", {31'b0, n < 400}, 32'd1);
    tick(1);
    for (int i = 0; i < 4; i++) if (m_ph[i] == 2) begin
      chk("conv_len", last_run[i], CONV);
      m_res[i] = adc; m_ph[i] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [3:0] b; logic [2:0] p; logic [7:0] d; int op;
    for (int i = 0; i < 4; i++) begin m_err[i] = 0; e_cnt[i] = 0; run[i] = 0; last_run[i] = 0; end
    model_clear();
    tick(3);
    for (int i = 0; i < 4; i++) begin
      chk("rst_oe", oe[i], 0); chk("rst_dout", dout[i], 0); chk("rst_lamp", lamp[i], 0);
      chk("rst_busy", busy[i], 0); chk("rst_err", err[i], 0);
    end
    reset_n = 1;
    tick(SYNC + 2);
    stable = 1;

    // selected vs unselected write
    wr(4'b0001, 1, 8'h5A);
    chk("lamp_sel", lamp[0], 8'h5A); chk("lamp_unsel", lamp[1], 8'h00);
    wr(4'b0010, 1, 8'h77);
    chk("lamp_keep", lamp[0], 8'h5A); chk("lamp_c1", lamp[1], 8'h77);

    // port-0 read of card inputs
    rd(4'b0001, 0, 8'hC3);
    chk("rd_port0", rd_seen, 8'hC3);

    // mux latch, settle, start, convert
    adc = 16'h1234;
    wr(4'b0001, 3, 8'h07);
    wr(4'b0001, 3, 8'hEE);
    chk("busy_start", busy[0], 1);
    wait_conv();
    chk("mux_latched", mux[0], 8'h07);
    chk("conv_cycles", last_run[0], 40);
    rd(4'b0001, 5, 8'h00); chk("adc_high", rd_seen, 8'h12);
    rd(4'b0001, 6, 8'h00); chk("adc_low", rd_seen, 8'h34);

    // both strobes low together
    e0 = e_cnt[0];
    bx = 4'b0001; addr = 1; din = 8'h33; tick(1);
    rdp = 0; wrp = 0; tick(5);
    rdp = 1; wrp = 1; tick(SYNC + 3); bx = 0; tick(1);
    m_err[0]++;
    chk("both_low_err", e_cnt[0] - e0, 1);
    chk("both_low_lamp", lamp[0], 8'h5A);

    // port-3 write during a conversion
    adc = 16'hBEEF; e0 = e_cnt[0];
    wr(4'b0001, 3, 8'h20);
    wr(4'b0001, 3, 8'h55);
    wr(4'b0001, 3, 8'h99);
    wait_conv();
    chk("conv_wr_err", e_cnt[0] - e0, 1);
    chk("conv_wr_mux", mux[0], 8'h20);

    // lamp reset mid-conversion
    wr(4'b0001, 1, 8'hFF);
    wr(4'b0001, 3, 8'h05);
    wr(4'b0001, 3, 8'h00);
    tick(5);
    stable = 0; lrst = 1;
    tick(SYNC + 3);
    for (int i = 0; i < 4; i++) begin chk("lrst_lamp", lamp[i], 0); chk("lrst_busy", busy[i], 0); end
    lrst = 0;
    tick(SYNC + 2);
    model_clear(); stable = 1;
    wr(4'b0001, 3, 8'h0A);
    chk("lrst_adc_idle", mux[0], 8'h0A);

    // broadcast write, per-slot reads
    wr(4'b1111, 2, 8'hA5);
    for (int i = 0; i < 4; i++) chk("bcast_aux", aux[i], 8'hA5);
    for (int i = 0; i < 4; i++) begin b = 4'b0001 << i; rd(b, 2, 8'h00); end

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2); b = 4'($urandom_range(0, 15));
      p = 3'($urandom_range(0, 7)); d = 8'($urandom);
      if (op < 2) begin
        adc = 16'($urandom);
        wr(b, p, d);
        if (m_ph[0] == 2 || m_ph[1] == 2 || m_ph[2] == 2 || m_ph[3] == 2) wait_conv();
      end else rd(b, p, 8'($urandom));
    end

    // async reset during a read
    bx = 4'b0001; addr = 1; rd_port = 1; tick(SYNC + 1);
    rd_active = 1; rdp = 0;
    tick(SYNC + 2);
    chk("pre_rst_oe", oe[0], 1);
    stable = 0; reset_n = 0; #1;
    chk("rst_async_oe", oe[0], 0);
    chk("rst_async_lamp", lamp[0], 0);
    rdp = 1; bx = 0; rd_active = 0; model_clear();
    tick(3); reset_n = 1;
    tick(SYNC + 2); stable = 1;
    tick(2);

    for (int i = 0; i < 4; i++) chk($sformatf("err_count%0d", i), e_cnt[i], m_err[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
